// File: rtl/taxi_mac_pause_pkg.sv
// Shared constants and FSM state type for the MAC pause-frame controllers.
package taxi_mac_pause_pkg;

  localparam logic [15:0] ETH_TYPE_MCF = 16'h8808;
  localparam logic [15:0] OPCODE_LFC   = 16'h0001;
  localparam logic [15:0] OPCODE_PFC   = 16'h0101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/taxi_mac_pause_ctrl_tx.sv
// Transmit-side pause (XOFF/XON) MAC control frame request generator.
// Priority flow control is built in when TAXI_MAC_PAUSE_PFC_EN is defined.
module taxi_mac_pause_ctrl_tx
  import taxi_mac_pause_pkg::*;
#(
  parameter int MCF_PARAMS_SIZE = 18
) (
  input  logic                         clk,
  input  logic                         rst,

  output logic                         mcf_valid,
  input  logic                         mcf_ready,
  output logic [47:0]                  mcf_eth_dst,
  output logic [47:0]                  mcf_eth_src,
  output logic [15:0]                  mcf_eth_type,
  output logic [15:0]                  mcf_opcode,
  output logic [MCF_PARAMS_SIZE*8-1:0] mcf_params,

  input  logic                         tx_lfc_req,
  input  logic                         tx_lfc_resend,
`ifdef TAXI_MAC_PAUSE_PFC_EN
  input  logic [7:0]                   tx_pfc_req,
`endif
  input  logic                         quanta_tick,

  input  logic                         cfg_tx_lfc_en,
`ifdef TAXI_MAC_PAUSE_PFC_EN
  input  logic                         cfg_tx_pfc_en,
`endif
  input  logic [47:0]                  cfg_eth_dst,
  input  logic [47:0]                  cfg_eth_src,
  input  logic [15:0]                  cfg_quanta,
  input  logic [15:0]                  cfg_refresh,

  output logic                         stat_tx_pkt,
  output logic                         stat_tx_xoff,
  output logic                         stat_tx_xon
);

  localparam int PW = MCF_PARAMS_SIZE * 8;

  state_t        state;
  state_t        state_next;
  logic          pending;
  logic          lfc_prev;
  logic          sent_xoff;
  logic [15:0]   refresh_cnt;
  logic [15:0]   refresh_inc;
`ifdef TAXI_MAC_PAUSE_PFC_EN
  logic [7:0]    pfc_prev;
`endif

  logic          pfc_mode;
  logic          enabled;
  logic          req_level;
  logic          req_edge;
  logic          xoff_active;
  logic          refresh_hit;
  logic          launch;
  logic          handshake;
  logic [15:0]   quanta_sel;
  logic [15:0]   opcode_next;
  logic [PW-1:0] params_next;

  // PFC, when enabled, replaces LFC as the active request source.
  always_comb begin
    pfc_mode  = 1'b0;
    enabled   = cfg_tx_lfc_en;
    req_level = tx_lfc_req;
    req_edge  = tx_lfc_req ^ lfc_prev;
`ifdef TAXI_MAC_PAUSE_PFC_EN
    if (cfg_tx_pfc_en) begin
      pfc_mode  = 1'b1;
      enabled   = 1'b1;
      req_level = |tx_pfc_req;
      req_edge  = |(tx_pfc_req ^ pfc_prev);
    end
`endif
  end

  assign xoff_active = req_level && (cfg_refresh != 16'd0);
  assign refresh_inc = refresh_cnt + 16'd1;
  assign refresh_hit = xoff_active && quanta_tick && (refresh_inc >= cfg_refresh);

  always_comb begin
    state_next = state;
    launch     = 1'b0;
    handshake  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending && enabled) begin
          launch     = 1'b1;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (mcf_ready) begin
          handshake  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    quanta_sel  = req_level ? cfg_quanta : 16'd0;
    opcode_next = OPCODE_LFC;
    params_next = '0;
    if (!pfc_mode) begin
      params_next[7:0]  = quanta_sel[15:8];
      params_next[15:8] = quanta_sel[7:0];
    end
`ifdef TAXI_MAC_PAUSE_PFC_EN
    else begin
      opcode_next       = OPCODE_PFC;
      params_next[15:8] = 8'hFF;
      for (int i = 0; i < 8; i++) begin
        if (tx_pfc_req[i]) begin
          params_next[8*(2+2*i) +: 8] = cfg_quanta[15:8];
          params_next[8*(3+2*i) +: 8] = cfg_quanta[7:0];
        end
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  assign mcf_valid = (state == ST_SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= 1'b0;
      lfc_prev     <= 1'b0;
`ifdef TAXI_MAC_PAUSE_PFC_EN
      pfc_prev     <= 8'd0;
`endif
      refresh_cnt  <= 16'd0;
      sent_xoff    <= 1'b0;
      mcf_eth_dst  <= '0;
      mcf_eth_src  <= '0;
      mcf_eth_type <= '0;
      mcf_opcode   <= '0;
      mcf_params   <= '0;
      stat_tx_pkt  <= 1'b0;
      stat_tx_xoff <= 1'b0;
      stat_tx_xon  <= 1'b0;
    end else begin
      lfc_prev <= tx_lfc_req;
`ifdef TAXI_MAC_PAUSE_PFC_EN
      pfc_prev <= tx_pfc_req;
`endif
      // The launch samples the live level, so a same-cycle event is already covered.
      if (launch)
        pending <= 1'b0;
      else if (req_edge || tx_lfc_resend || refresh_hit)
        pending <= 1'b1;

      if (launch || !xoff_active || refresh_hit)
        refresh_cnt <= 16'd0;
      else if (quanta_tick)
        refresh_cnt <= refresh_inc;

      if (launch) begin
        sent_xoff    <= req_level;
        mcf_eth_dst  <= cfg_eth_dst;
        mcf_eth_src  <= cfg_eth_src;
        mcf_eth_type <= ETH_TYPE_MCF;
        mcf_opcode   <= opcode_next;
        mcf_params   <= params_next;
      end

      stat_tx_pkt  <= handshake;
      stat_tx_xoff <= handshake && sent_xoff;
      stat_tx_xon  <= handshake && !sent_xoff;
    end
  end

endmodule

// File: tb/tb_taxi_mac_pause_ctrl_tx.sv
// Directed scoreboard bench for taxi_mac_pause_ctrl_tx (PFC steps under TAXI_MAC_PAUSE_PFC_EN).
module tb_taxi_mac_pause_ctrl_tx;

  localparam int PS = 18;
  localparam int PW = PS * 8;
  typedef logic [PW-1:0] w_t;

  typedef struct {
    logic [15:0] opcode;
    w_t          params;
    logic        xoff;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mcf_valid;
  logic          mcf_ready = 1'b1;
  logic [47:0]   mcf_eth_dst;
  logic [47:0]   mcf_eth_src;
  logic [15:0]   mcf_eth_type;
  logic [15:0]   mcf_opcode;
  logic [PW-1:0] mcf_params;
  logic          tx_lfc_req = 1'b0;
  logic          tx_lfc_resend = 1'b0;
  logic          quanta_tick = 1'b0;
  logic          cfg_tx_lfc_en = 1'b1;
  logic [47:0]   cfg_eth_dst = 48'h0180_C200_0001;
  logic [47:0]   cfg_eth_src = 48'h0200_00AA_BBCC;
  logic [15:0]   cfg_quanta = 16'hFFFF;
  logic [15:0]   cfg_refresh = 16'd0;
  logic          stat_tx_pkt;
  logic          stat_tx_xoff;
  logic          stat_tx_xon;
`ifdef TAXI_MAC_PAUSE_PFC_EN
  logic [7:0]    tx_pfc_req = 8'd0;
  logic          cfg_tx_pfc_en = 1'b0;
`endif

  taxi_mac_pause_ctrl_tx #(.MCF_PARAMS_SIZE(PS)) dut (
    .clk           (clk),
    .rst           (rst),
    .mcf_valid     (mcf_valid),
    .mcf_ready     (mcf_ready),
    .mcf_eth_dst   (mcf_eth_dst),
    .mcf_eth_src   (mcf_eth_src),
    .mcf_eth_type  (mcf_eth_type),
    .mcf_opcode    (mcf_opcode),
    .mcf_params    (mcf_params),
    .tx_lfc_req    (tx_lfc_req),
    .tx_lfc_resend (tx_lfc_resend),
`ifdef TAXI_MAC_PAUSE_PFC_EN
    .tx_pfc_req    (tx_pfc_req),
`endif
    .quanta_tick   (quanta_tick),
    .cfg_tx_lfc_en (cfg_tx_lfc_en),
`ifdef TAXI_MAC_PAUSE_PFC_EN
    .cfg_tx_pfc_en (cfg_tx_pfc_en),
`endif
    .cfg_eth_dst   (cfg_eth_dst),
    .cfg_eth_src   (cfg_eth_src),
    .cfg_quanta    (cfg_quanta),
    .cfg_refresh   (cfg_refresh),
    .stat_tx_pkt   (stat_tx_pkt),
    .stat_tx_xoff  (stat_tx_xoff),
    .stat_tx_xon   (stat_tx_xon)
  );

  always #5 clk = ~clk;

  int     compared   = 0;
  int     mismatched = 0;
  int     frames_seen = 0;
  frame_t sb[$];
  logic   stat_due  = 1'b0;
  logic   stat_xoff = 1'b0;

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t lfc(input logic [15:0] q, input logic xoff);
    frame_t f;
    f.opcode        = 16'h0001;
    f.params        = '0;
    f.params[7:0]   = q[15:8];
    f.params[15:8]  = q[7:0];
    f.xoff          = xoff;
    return f;
  endfunction

  // Frame monitor: compare on the handshake, then check the stat pulse one cycle later.
  always @(negedge clk) begin
    if (stat_due) begin
      chk("stat_tx_pkt",  w_t'(stat_tx_pkt),  w_t'(1'b1));
      chk("stat_tx_xoff", w_t'(stat_tx_xoff), w_t'(stat_xoff));
      chk("stat_tx_xon",  w_t'(stat_tx_xon),  w_t'(!stat_xoff));
      stat_due = 1'b0;
    end
    if (!rst && mcf_valid && mcf_ready) begin
      frame_t e;
      frames_seen++;
      chk("frame_expected", w_t'(sb.size() != 0), w_t'(1'b1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("opcode",   w_t'(mcf_opcode),   w_t'(e.opcode));
        chk("params",   mcf_params,         e.params);
        chk("eth_type", w_t'(mcf_eth_type), w_t'(16'h8808));
        chk("eth_dst",  w_t'(mcf_eth_dst),  w_t'(cfg_eth_dst));
        chk("eth_src",  w_t'(mcf_eth_src),  w_t'(cfg_eth_src));
        stat_xoff = e.xoff;
        stat_due  = 1'b1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_quanta();
    quanta_tick = 1'b1;
    tick(1);
    quanta_tick = 1'b0;
    tick(2);
  endtask

  task automatic wait_frames(input string tag, input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(tag, w_t'(frames_seen), w_t'(target));
    tick(2);
  endtask

  initial begin
    int base;

    // Reset state
    tick(3);
    chk("rst_valid",    w_t'(mcf_valid),    w_t'(1'b0));
    chk("rst_opcode",   w_t'(mcf_opcode),   w_t'(16'h0));
    chk("rst_params",   mcf_params,         w_t'(0));
    chk("rst_eth_type", w_t'(mcf_eth_type), w_t'(16'h0));
    chk("rst_eth_dst",  w_t'(mcf_eth_dst),  w_t'(48'h0));
    chk("rst_stat_pkt", w_t'(stat_tx_pkt),  w_t'(1'b0));
    rst = 1'b0;
    tick(5);
    chk("idle_no_frame", w_t'(frames_seen), w_t'(0));

    // XOFF on rising request, full quanta
    sb.push_back(lfc(16'hFFFF, 1'b1));
    tx_lfc_req = 1'b1;
    tick(1);
    chk("launch_not_early", w_t'(mcf_valid), w_t'(1'b0));
    tick(1);
    chk("launch_latency", w_t'(mcf_valid), w_t'(1'b1));
    wait_frames("xoff_frame", 1, 10);

    // Refresh every 4 quanta ticks while XOFF is held
    cfg_refresh = 16'd4;
    for (int r = 0; r < 2; r++) begin
      base = frames_seen;
      sb.push_back(lfc(16'hFFFF, 1'b1));
      repeat (3) pulse_quanta();
      tick(5);
      chk("refresh_not_early", w_t'(frames_seen), w_t'(base));
      pulse_quanta();
      wait_frames("refresh_frame", base + 1, 10);
    end

    // XON on falling request, then ticks must not refresh
    base = frames_seen;
    sb.push_back(lfc(16'h0000, 1'b0));
    tx_lfc_req = 1'b0;
    wait_frames("xon_frame", base + 1, 10);
    repeat (6) pulse_quanta();
    chk("no_refresh_in_xon", w_t'(frames_seen), w_t'(base + 1));

    // Back-pressure: fields stable while request toggles, one XON follow-up
    base = frames_seen;
    mcf_ready = 1'b0;
    sb.push_back(lfc(16'hFFFF, 1'b1));
    tx_lfc_req = 1'b1;
    tick(2);
    for (int i = 0; i < 10; i++) begin
      chk("hold_valid",  w_t'(mcf_valid),  w_t'(1'b1));
      chk("hold_opcode", w_t'(mcf_opcode), w_t'(16'h0001));
      chk("hold_params", mcf_params,       lfc(16'hFFFF, 1'b1).params);
      if (i == 2) tx_lfc_req = 1'b0;
      tick(1);
    end
    sb.push_back(lfc(16'h0000, 1'b0));
    mcf_ready = 1'b1;
    wait_frames("held_then_xon", base + 2, 20);
    tick(10);
    chk("single_follow_up", w_t'(frames_seen), w_t'(base + 2));

    // Reset during SEND drops the request; nothing after release
    base = frames_seen;
    mcf_ready = 1'b0;
    tx_lfc_resend = 1'b1;
    tick(1);
    tx_lfc_resend = 1'b0;
    tick(1);
    chk("resend_launch", w_t'(mcf_valid), w_t'(1'b1));
    rst = 1'b1;
    tick(1);
    chk("rst_in_send_valid", w_t'(mcf_valid),  w_t'(1'b0));
    chk("rst_in_send_op",    w_t'(mcf_opcode), w_t'(16'h0));
    rst = 1'b0;
    mcf_ready = 1'b1;
    tick(20);
    chk("no_frame_after_rst", w_t'(frames_seen), w_t'(base));
    chk("idle_after_rst",     w_t'(mcf_valid),   w_t'(1'b0));

    // Disable during SEND: frame completes, pending held until re-enable
    base = frames_seen;
    cfg_quanta = 16'h1234;
    mcf_ready = 1'b0;
    sb.push_back(lfc(16'h1234, 1'b1));
    tx_lfc_req = 1'b1;
    tick(2);
    chk("dis_launch", w_t'(mcf_valid), w_t'(1'b1));
    cfg_tx_lfc_en = 1'b0;
    tick(3);
    chk("dis_hold_valid", w_t'(mcf_valid), w_t'(1'b1));
    tx_lfc_req = 1'b0;
    tick(2);
    mcf_ready = 1'b1;
    wait_frames("dis_complete", base + 1, 10);
    tick(10);
    chk("dis_no_launch", w_t'(frames_seen), w_t'(base + 1));
    chk("dis_idle",      w_t'(mcf_valid),   w_t'(1'b0));
    sb.push_back(lfc(16'h0000, 1'b0));
    cfg_tx_lfc_en = 1'b1;
    wait_frames("reenable_xon", base + 2, 10);

`ifdef TAXI_MAC_PAUSE_PFC_EN
    // PFC priorities 0 and 2 paused
    begin
      frame_t f;
      base = frames_seen;
      cfg_tx_pfc_en = 1'b1;
      f.opcode = 16'h0101;
      f.params = '0;
      f.params[15:8]  = 8'hFF;
      f.params[23:16] = 8'h12;
      f.params[31:24] = 8'h34;
      f.params[55:48] = 8'h12;
      f.params[63:56] = 8'h34;
      f.xoff = 1'b1;
      sb.push_back(f);
      tx_pfc_req = 8'h05;
      wait_frames("pfc_xoff", base + 1, 10);
      f.params = '0;
      f.params[15:8] = 8'hFF;
      f.xoff = 1'b0;
      sb.push_back(f);
      tx_pfc_req = 8'h00;
      wait_frames("pfc_xon", base + 2, 10);
      cfg_tx_pfc_en = 1'b0;
    end
`endif

    tick(5);
    chk("scoreboard_drained", w_t'(sb.size()), w_t'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
